// File: rtl/axi_dma_w.sv
// rtl/axi_dma_w.sv - AXI4 write-master burst engine, one burst in flight at a time
//
// Purpose: accepts one burst of write beats per request from the internal databus
// and drives the AXI AW, W and B channels toward the DDR controller. A non-OKAY
// write response is reported on `error` until the next response arrives.
//
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   valid/ready           - databus request/beat handshake (ready = beat taken)
//   addr, len             - burst start address and beats-minus-one (taken at AW handshake)
//   wdata, wstrb          - beat payload
//   error                 - last burst received a non-OKAY bresp
//   m_axi_aw*             - AXI write address channel
//   m_axi_w*              - AXI write data channel
//   m_axi_b*              - AXI write response channel
module axi_dma_w #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int LEN_W  = 8,
    parameter int ID_W   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [LEN_W-1:0]    len,
    output logic                ready,
    output logic                error,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [LEN_W-1:0]    m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready
);

    localparam logic [2:0] AWSIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        W_ADDR_HS = 2'd0,
        W_DATA    = 2'd1,
        W_RESP    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    // One bit wider than len so a 2^LEN_W-beat burst never wraps before the compare.
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             error_q, error_d;

    logic                awvalid_c, wvalid_c, wlast_c, ready_c, bready_c;
    logic [DATA_W-1:0]   wdata_c;
    logic [DATA_W/8-1:0] wstrb_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= W_ADDR_HS;
            len_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        error_d   = error_q;
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        wlast_c   = 1'b0;
        ready_c   = 1'b0;
        bready_c  = 1'b0;
        wdata_c   = '0;
        wstrb_c   = '0;
        case (state_q)
            W_ADDR_HS: begin
                awvalid_c = valid;
                cnt_d     = '0;
                if (valid && m_axi_awready) begin
                    len_d   = len;
                    state_d = W_DATA;
                end
            end
            W_DATA: begin
                wvalid_c = valid;
                wdata_c  = wdata;
                wstrb_c  = wstrb;
                wlast_c  = (cnt_q == {1'b0, len_q});
                if (valid && m_axi_wready) begin
                    ready_c = 1'b1;
                    cnt_d   = cnt_q + {{LEN_W{1'b0}}, 1'b1};
                    if (wlast_c) begin
                        state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bready_c = 1'b1;
                if (m_axi_bvalid) begin
                    error_d = (m_axi_bresp != 2'b00);
                    state_d = W_ADDR_HS;
                end
            end
            default: begin
                state_d = W_ADDR_HS;
            end
        endcase
    end

    // Handshake outputs are forced low while reset is held so they drop the
    // moment reset asserts, even if the requester keeps valid high.
    assign ready         = ready_c & rst;
    assign m_axi_awvalid = awvalid_c & rst;
    assign m_axi_wvalid  = wvalid_c & rst;
    assign m_axi_wlast   = wlast_c & rst;
    assign m_axi_bready  = bready_c & rst;
    assign m_axi_wdata   = wdata_c;
    assign m_axi_wstrb   = wstrb_c;
    assign error         = error_q;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = len;
    assign m_axi_awsize  = AWSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'h2;
    assign m_axi_awprot  = 3'b010;
    assign m_axi_awqos   = 4'h0;

endmodule

// File: tb/tb_axi_dma_w.sv
// tb/tb_axi_dma_w.sv - randomized self-checking bench for axi_dma_w
module tb_axi_dma_w;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 8;
    localparam int ID_W   = 1;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                valid = 1'b0;
    logic [ADDR_W-1:0]   addr = '0;
    logic [DATA_W-1:0]   wdata = '0;
    logic [DATA_W/8-1:0] wstrb = '0;
    logic [LEN_W-1:0]    len = '0;
    logic                ready, error;
    logic [ID_W-1:0]     m_axi_awid;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [LEN_W-1:0]    m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic                m_axi_awlock;
    logic [3:0]          m_axi_awcache;
    logic [2:0]          m_axi_awprot;
    logic [3:0]          m_axi_awqos;
    logic                m_axi_awvalid;
    logic                m_axi_awready = 1'b0;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic                m_axi_wlast, m_axi_wvalid;
    logic                m_axi_wready = 1'b0;
    logic [1:0]          m_axi_bresp = 2'b00;
    logic                m_axi_bvalid = 1'b0;
    logic                m_axi_bready;

    axi_dma_w #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .len(len), .ready(ready), .error(error),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level reference: which phase the burst is in, how many
    // beats it was granted and which beat is next.
    int          m_phase = 0;   // 0 waiting for address, 1 moving data, 2 awaiting response
    int          m_len   = 0;
    int          m_beat  = 0;
    logic [31:0] m_addr  = '0;
    logic        m_err   = 1'b0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          wlast_hs = 0;

    function automatic logic [DATA_W-1:0] beat_data(input logic [31:0] a, input int b);
        return {8{a + 32'(b)}};
    endfunction

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic e_aw, e_w, e_last, e_rdy, e_b;
        if (!rst) begin
            m_phase = 0; m_len = 0; m_beat = 0; m_err = 1'b0;
            chk("rst_ready",   ready, 0);
            chk("rst_awvalid", m_axi_awvalid, 0);
            chk("rst_wvalid",  m_axi_wvalid, 0);
            chk("rst_wlast",   m_axi_wlast, 0);
            chk("rst_bready",  m_axi_bready, 0);
            chk("rst_error",   error, 0);
        end else begin
            e_aw   = (m_phase == 0) && valid;
            e_w    = (m_phase == 1) && valid;
            e_last = (m_phase == 1) && (m_beat == m_len);
            e_rdy  = e_w && m_axi_wready;
            e_b    = (m_phase == 2);
            chk("awvalid", m_axi_awvalid, e_aw);
            chk("wvalid",  m_axi_wvalid, e_w);
            chk("wlast",   m_axi_wlast, e_last);
            chk("ready",   ready, e_rdy);
            chk("bready",  m_axi_bready, e_b);
            chk("error",   error, m_err);
            chk("wdata",   m_axi_wdata, (m_phase == 1) ? wdata : '0);
            chk("wstrb",   m_axi_wstrb, (m_phase == 1) ? wstrb : '0);
            if (e_rdy) chk("beat_order", m_axi_wdata, beat_data(m_addr, m_beat));
            chk("awaddr",  m_axi_awaddr, addr);
            chk("awlen",   m_axi_awlen, len);
            chk("awconst", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                            m_axi_awcache, m_axi_awprot, m_axi_awqos},
                           {1'b0, 3'd5, 2'b01, 1'b0, 4'h2, 3'b010, 4'h0});
            case (m_phase)
                0: if (valid && m_axi_awready) begin
                    m_phase = 1; m_len = int'(len); m_addr = addr; m_beat = 0;
                end
                1: if (e_rdy) begin
                    acc_cnt++;
                    if (m_axi_wlast) wlast_hs++;
                    if (m_beat == m_len) m_phase = 2;
                    else m_beat++;
                end
                default: if (m_axi_bvalid) begin
                    m_err = (m_axi_bresp != 2'b00);
                    m_phase = 0;
                    done_cnt++;
                end
            endcase
        end
    end

    // Drives one request plus the slave side. Returns at posedge+1 once the
    // response handshake happened, or once stop_at beats were taken.
    task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] br,
                             input int aw_hold, input bit rnd, input bit chg_len, input int stop_at,
                             output int cyc, output int beats);
        int a0, d0, beat;
        a0 = acc_cnt; d0 = done_cnt; cyc = 0;
        addr = a; len = l; valid = 1'b1; wdata = beat_data(a, 0); wstrb = $urandom;
        m_axi_bresp = br;
        for (int i = 0; i < 3000; i++) begin
            m_axi_awready = (cyc >= aw_hold) && (!rnd || ($urandom_range(0, 1) == 1));
            m_axi_wready  = !rnd || ($urandom_range(0, 2) != 0);
            m_axi_bvalid  = !rnd || ($urandom_range(0, 1) == 1);
            @(posedge clk); cyc++; #1;
            beat = acc_cnt - a0;
            if (done_cnt != d0 || (stop_at >= 0 && beat >= stop_at)) break;
            if (chg_len && m_phase != 0) begin
                len = 8'd7; addr = $urandom;
            end
            wdata = beat_data(a, beat); wstrb = $urandom;
            valid = !rnd || ($urandom_range(0, 3) != 0);
        end
        beats = acc_cnt - a0;
        if (stop_at < 0) begin
            chk("burst_done", done_cnt - d0, 1);
            valid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        end
    endtask

    initial begin
        int cyc, beats, w0;
        logic [7:0] rl;
        logic [1:0] rb;
        #23;
        chk("reset_awvalid", m_axi_awvalid, 0);
        chk("reset_error", error, 0);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;

        // Single beat: 1 AW + 1 W + 1 B = 3 cycles.
        w0 = wlast_hs;
        run_burst(32'h1000, 8'd0, 2'b00, 0, 1'b0, 1'b0, -1, cyc, beats);
        chk("single_cycles", cyc, 3);
        chk("single_beats", beats, 1);
        chk("single_wlast", wlast_hs - w0, 1);
        chk("single_error", error, 0);

        // Burst of 4 with random gaps.
        len = 8'd3; #1;
        chk("awlen_lit", m_axi_awlen, 3);
        chk("awsize_lit", m_axi_awsize, 5);
        w0 = wlast_hs;
        run_burst(32'h2000, 8'd3, 2'b00, 0, 1'b1, 1'b0, -1, cyc, beats);
        chk("burst4_beats", beats, 4);
        chk("burst4_wlast", wlast_hs - w0, 1);

        // Error response then recovery.
        run_burst(32'h3000, 8'd2, 2'b10, 0, 1'b0, 1'b0, -1, cyc, beats);
        chk("err_set", error, 1);
        run_burst(32'h3100, 8'd1, 2'b00, 0, 1'b0, 1'b0, -1, cyc, beats);
        chk("err_clr", error, 0);

        // len changed to 7 after AW handshake of a 2-beat burst.
        run_burst(32'h4000, 8'd1, 2'b00, 0, 1'b0, 1'b1, -1, cyc, beats);
        chk("stable_beats", beats, 2);

        // awready held low 5 cycles: 5 + AW + W + B.
        run_burst(32'h5000, 8'd0, 2'b00, 5, 1'b0, 1'b0, -1, cyc, beats);
        chk("bp_cycles", cyc, 8);

        // Longest burst: 1 + 256 + 1 cycles.
        run_burst(32'h6000, 8'd255, 2'b01, 0, 1'b0, 1'b0, -1, cyc, beats);
        chk("max_cycles", cyc, 258);
        chk("max_beats", beats, 256);
        chk("max_error", error, 1);

        // Reset after beat 2 of 4 with valid and wready still high.
        run_burst(32'h7000, 8'd3, 2'b00, 0, 1'b0, 1'b0, 2, cyc, beats);
        chk("pre_rst_beats", beats, 2);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_wvalid", m_axi_wvalid, 0);
        chk("mid_rst_awvalid", m_axi_awvalid, 0);
        chk("mid_rst_wlast", m_axi_wlast, 0);
        chk("mid_rst_bready", m_axi_bready, 0);
        valid = 1'b0; m_axi_wready = 1'b0; m_axi_awready = 1'b0; m_axi_bvalid = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1;
        run_burst(32'h8000, 8'd0, 2'b00, 0, 1'b0, 1'b0, -1, cyc, beats);
        chk("post_rst_cycles", cyc, 3);
        chk("post_rst_beats", beats, 1);

        // Random bursts against the reference model.
        for (int k = 0; k < 25; k++) begin
            rl = 8'($urandom_range(0, 15));
            rb = 2'($urandom_range(0, 3));
            run_burst($urandom, rl, rb, $urandom_range(0, 3), 1'b1, k[0], -1, cyc, beats);
            chk("rand_beats", beats, int'(rl) + 1);
            chk("rand_error", error, (rb != 2'b00));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
